picorv32_wb_master: RTL

Bridge between the PicoRV32 native memory interface and a classic single-transfer Wishbone master port. Sits directly upstream of the Wishbone slave peripherals, such as the 32-bit register slave. It converts each mem_valid request into exactly one Wishbone cycle and returns read data and mem_ready to the core. Non-pipelined: one outstanding transfer at a time.

---
 rtl/picorv32_wb_master.sv | 122 ++++++++++++
 1 files changed

// File: rtl/picorv32_wb_master.sv
// PicoRV32 native memory bus to classic single-transfer Wishbone master bridge.
// Optional ack timeout enabled by defining WB_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module picorv32_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } wb_req_t;

  state_e      state_q;
  wb_req_t     req_q;
  logic        cyc_q;
  logic        ready_q;
  logic [31:0] rdata_q;

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        err_q;
`endif

  // mem_instr carries no meaning on Wishbone; low address bits are dropped on purpose.
  logic unused_inputs;
  assign unused_inputs = ^{mem_instr, mem_addr[1:0], TIMEOUT_CYCLES[0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      cyc_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef WB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (mem_valid) begin
            req_q.adr <= {mem_addr[31:2], 2'b00};
            req_q.dat <= mem_wdata;
            req_q.we  <= |mem_wstrb;
            req_q.sel <= (|mem_wstrb) ? mem_wstrb : 4'hF;
            cyc_q     <= 1'b1;
            state_q   <= ACTIVE;
`ifdef WB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        ACTIVE: begin
          // Ack is checked first so a coincident timeout still completes normally.
          if (wbm_ack_i) begin
            cyc_q   <= 1'b0;
            ready_q <= 1'b1;
            if (!req_q.we) rdata_q <= wbm_dat_i;
            state_q <= RESP;
          end
`ifdef WB_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            cyc_q   <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            if (!req_q.we) rdata_q <= 32'hFFFF_FFFF;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        // The core still holds mem_valid here; it must not start a new transfer.
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign wbm_adr_o = req_q.adr;
  assign wbm_dat_o = req_q.dat;
  assign wbm_we_o  = req_q.we;
  assign wbm_sel_o = req_q.sel;
  assign wbm_stb_o = cyc_q;
  assign wbm_cyc_o = cyc_q;
`ifdef WB_TIMEOUT_EN
  assign bus_err_o = err_q;
`else
  assign bus_err_o = 1'b0;
`endif

endmodule
